// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// Optional early divide-by-zero detection is enabled by defining MULDIV_EARLY_ZERO_EN.
package muldiv_pkg;

    localparam int ITER_WIDTH = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH_A,
        ST_FETCH_A_WAIT,
        ST_FETCH_B,
        ST_FETCH_B_WAIT,
        ST_CLEAR,
        ST_RUN,
        ST_WRITE,
        ST_EXC
    } stateT;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_DIVM = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    localparam logic [1:0] FETCH_NONE = 2'b00;
    localparam logic [1:0] FETCH_A    = 2'b01;
    localparam logic [1:0] FETCH_B    = 2'b10;

    function automatic logic isDivOp(input logic [1:0] opCode);
        return (opCode == OP_DIV) || (opCode == OP_DIVM);
    endfunction

endpackage

// File: rtl/muldiv_iter_counter.sv
// Loadable down-counter tracking the Mult/Div iteration window; saturates at zero.
module muldiv_iter_counter
    import muldiv_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [ITER_WIDTH-1:0] loadValue,
    input  logic                  dec,
    output logic                  isZero
);

    logic [ITER_WIDTH-1:0] countReg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            countReg <= '0;
        end else if (load) begin
            countReg <= loadValue;
        end else if (dec && (countReg != '0)) begin
            countReg <= countReg - 1'b1;
        end
    end

    assign isZero = (countReg == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// Moore sequencer for the shared Mult/Div unit, operand latches and Hi/Lo loads.
// Define MULDIV_EARLY_ZERO_EN to raise the divide-by-zero exception from CLEAR using divisor_zero.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int ITER_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    input  logic       zero_div,
    input  logic       divisor_zero,
    output logic       busy,
    output logic       done,
    output logic       zero_div_exc,
    output logic       unit_reset,
    output logic       mult_div_sel,
    output logic       mem_a_sel,
    output logic       mem_b_sel,
    output logic [1:0] mem_fetch,
    output logic       aux_a_load,
    output logic       aux_b_load,
    output logic       hi_load,
    output logic       lo_load
);

    localparam logic [ITER_WIDTH-1:0] ITER_LOAD = ITER_WIDTH'(ITER_CYCLES - 1);

    stateT      stateReg;
    logic [1:0] opReg;
    logic       counterZero;
    logic       divActive;

    assign divActive = isDivOp(opReg);

    muldiv_iter_counter u_counter (
        .clk       (clk),
        .reset     (reset),
        .load      (stateReg == ST_CLEAR),
        .loadValue (ITER_LOAD),
        .dec       (stateReg == ST_RUN),
        .isZero    (counterZero)
    );

`ifndef MULDIV_EARLY_ZERO_EN
    logic unusedDivisorZero;
    assign unusedDivisorZero = divisor_zero;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg     <= ST_IDLE;
            opReg        <= OP_MULT;
            busy         <= 1'b0;
            done         <= 1'b0;
            zero_div_exc <= 1'b0;
            unit_reset   <= 1'b0;
            mult_div_sel <= 1'b0;
            mem_a_sel    <= 1'b0;
            mem_b_sel    <= 1'b0;
            mem_fetch    <= FETCH_NONE;
            aux_a_load   <= 1'b0;
            aux_b_load   <= 1'b0;
            hi_load      <= 1'b0;
            lo_load      <= 1'b0;
        end else begin
            // Every pulse output defaults low; states below raise what the next cycle needs.
            done         <= 1'b0;
            zero_div_exc <= 1'b0;
            unit_reset   <= 1'b0;
            mem_fetch    <= FETCH_NONE;
            aux_a_load   <= 1'b0;
            aux_b_load   <= 1'b0;
            hi_load      <= 1'b0;
            lo_load      <= 1'b0;
            case (stateReg)
                ST_IDLE: begin
                    if (start && (op != OP_RSVD)) begin
                        opReg        <= op;
                        busy         <= 1'b1;
                        mult_div_sel <= (op != OP_MULT);
                        mem_a_sel    <= (op == OP_DIVM);
                        mem_b_sel    <= (op == OP_DIVM);
                        if (op == OP_DIVM) begin
                            stateReg  <= ST_FETCH_A;
                            mem_fetch <= FETCH_A;
                        end else begin
                            stateReg   <= ST_CLEAR;
                            unit_reset <= 1'b1;
                        end
                    end
                end
                ST_FETCH_A: begin
                    stateReg   <= ST_FETCH_A_WAIT;
                    aux_a_load <= 1'b1;
                end
                ST_FETCH_A_WAIT: begin
                    stateReg  <= ST_FETCH_B;
                    mem_fetch <= FETCH_B;
                end
                ST_FETCH_B: begin
                    stateReg   <= ST_FETCH_B_WAIT;
                    aux_b_load <= 1'b1;
                end
                ST_FETCH_B_WAIT: begin
                    stateReg   <= ST_CLEAR;
                    unit_reset <= 1'b1;
                end
                ST_CLEAR: begin
`ifdef MULDIV_EARLY_ZERO_EN
                    if (divActive && divisor_zero) begin
                        stateReg     <= ST_EXC;
                        zero_div_exc <= 1'b1;
                    end else begin
                        stateReg <= ST_RUN;
                    end
`else
                    stateReg <= ST_RUN;
`endif
                end
                ST_RUN: begin
                    // A divide fault wins over the final iteration.
                    if (divActive && zero_div) begin
                        stateReg     <= ST_EXC;
                        zero_div_exc <= 1'b1;
                    end else if (counterZero) begin
                        stateReg <= ST_WRITE;
                        done     <= 1'b1;
                        hi_load  <= 1'b1;
                        lo_load  <= 1'b1;
                    end
                end
                ST_WRITE, ST_EXC: begin
                    stateReg <= ST_IDLE;
                    busy     <= 1'b0;
                end
                default: begin
                    stateReg <= ST_IDLE;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized bench: a timeline model of each operation predicts every output on every cycle.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int ITER = 32;
`ifdef MULDIV_EARLY_ZERO_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [1:0] op = 2'b00;
    logic       zero_div = 1'b0;
    logic       divisor_zero = 1'b0;
    logic       busy, done, zero_div_exc, unit_reset, mult_div_sel, mem_a_sel, mem_b_sel;
    logic       aux_a_load, aux_b_load, hi_load, lo_load;
    logic [1:0] mem_fetch;

    int nCompared = 0;
    int nMismatched = 0;
    int cyc = 0;

    // Current operation as seen by the model (relative timeline from its start cycle).
    logic       txnValid = 1'b0;
    int         txnStart = 0;
    logic [1:0] txnOp = OP_MULT;
    int         txnFault = -1;
    logic       txnDz = 1'b0;
    logic       lastMd = 1'b0;
    logic       lastMem = 1'b0;

    muldiv_sequencer #(.ITER_CYCLES(ITER)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op           (op),
        .zero_div     (zero_div),
        .divisor_zero (divisor_zero),
        .busy         (busy),
        .done         (done),
        .zero_div_exc (zero_div_exc),
        .unit_reset   (unit_reset),
        .mult_div_sel (mult_div_sel),
        .mem_a_sel    (mem_a_sel),
        .mem_b_sel    (mem_b_sel),
        .mem_fetch    (mem_fetch),
        .aux_a_load   (aux_a_load),
        .aux_b_load   (aux_b_load),
        .hi_load      (hi_load),
        .lo_load      (lo_load)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int fetchCycles(input logic [1:0] o);
        return (o == OP_DIVM) ? 4 : 0;
    endfunction

    // Relative cycle of the done / exception pulse for an operation started at relative cycle 0.
    function automatic int endRel(input logic [1:0] o, input int fault, input logic dz,
                                  output logic isExc);
        int base;
        base = fetchCycles(o);
        isExc = 1'b0;
        if (o != OP_MULT && dz && EARLY_EN) begin
            isExc = 1'b1;
            return base + 2;
        end
        if (o != OP_MULT && fault >= base + 2 && fault <= base + ITER + 1) begin
            isExc = 1'b1;
            return fault + 1;
        end
        return base + ITER + 2;
    endfunction

    // Per-cycle compare: {busy,done,exc,unit_reset,md_sel,a_sel,b_sel,fetch[1:0],auxa,auxb,hi,lo}
    always @(negedge clk) begin
        logic [12:0] expv;
        logic [12:0] actv;
        logic        isExc;
        int          rel;
        int          e;
        int          base;
        expv = '0;
        expv[8] = lastMd;
        expv[7] = lastMem;
        expv[6] = lastMem;
        if (txnValid) begin
            rel  = cyc - txnStart;
            e    = endRel(txnOp, txnFault, txnDz, isExc);
            base = fetchCycles(txnOp);
            if (rel >= 1) begin
                expv[8] = (txnOp != OP_MULT);
                expv[7] = (txnOp == OP_DIVM);
                expv[6] = (txnOp == OP_DIVM);
            end
            if (rel >= 1 && rel <= e) begin
                expv[12] = 1'b1;
                if (base == 4) begin
                    if (rel == 1) expv[5:4] = FETCH_A;
                    if (rel == 2) expv[3] = 1'b1;
                    if (rel == 3) expv[5:4] = FETCH_B;
                    if (rel == 4) expv[2] = 1'b1;
                end
                if (rel == base + 1) expv[9] = 1'b1;
                if (rel == e) begin
                    if (isExc) expv[10] = 1'b1;
                    else begin
                        expv[11] = 1'b1;
                        expv[1]  = 1'b1;
                        expv[0]  = 1'b1;
                    end
                end
            end
        end
        actv = {busy, done, zero_div_exc, unit_reset, mult_div_sel, mem_a_sel, mem_b_sel,
                mem_fetch, aux_a_load, aux_b_load, hi_load, lo_load};
        nCompared++;
        if (actv !== expv) begin
            nMismatched++;
            $display("FAIL outputs cyc=%0d got=%b want=%b (busy,done,exc,urst,md,a,b,fetch,auxa,auxb,hi,lo)",
                     cyc, actv, expv);
        end
    end

    task automatic checkInt(input string name, input int got, input int want);
        nCompared++;
        if (got != want) begin
            nMismatched++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic commitSelects();
        if (txnValid) begin
            lastMd  = (txnOp != OP_MULT);
            lastMem = (txnOp == OP_DIVM);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the first cycle after the operation ends.
    task automatic doTxn(input logic [1:0] o, input int fault, input logic dz, input logic noise,
                         output int obsEnd, output logic obsExc, output int nEnds);
        int   rel;
        int   e;
        int   noiseRel;
        logic x;
        obsEnd = -1;
        obsExc = 1'b0;
        nEnds  = 0;
        commitSelects();
        txnValid = 1'b1;
        txnStart = cyc;
        txnOp    = o;
        txnFault = fault;
        txnDz    = dz;
        e = endRel(o, fault, dz, x);
        noiseRel = noise ? $urandom_range(1, e) : -1;
        start = 1'b1;
        op = o;
        divisor_zero = dz;
        zero_div = (fault == 0);
        rel = 0;
        while (rel <= e) begin
            @(posedge clk);
            #1;
            rel = cyc - txnStart;
            start = (rel == noiseRel);
            op = start ? 2'($urandom_range(0, 3)) : o;
            zero_div = (rel == fault);
            if (done || zero_div_exc) begin
                nEnds++;
                if (obsEnd < 0) begin
                    obsEnd = rel;
                    obsExc = zero_div_exc;
                end
            end
        end
        zero_div = 1'b0;
        $display("txn op=%0d fault=%0d dz=%0b noise=%0d -> end=%0d exc=%0b", o, fault, dz,
                 noiseRel, obsEnd, obsExc);
    endtask

    initial begin
        int   endCyc;
        int   nEnds;
        logic isExc;
        logic [1:0] o;
        int   fault;
        logic dz;
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        checkInt("reset_outputs_zero",
                 int'({busy, done, zero_div_exc, unit_reset, mult_div_sel, mem_a_sel, mem_b_sel,
                       mem_fetch, aux_a_load, aux_b_load, hi_load, lo_load}), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        doTxn(OP_MULT, -1, 1'b0, 1'b0, endCyc, isExc, nEnds);
        checkInt("mult_done_cycle", endCyc, 34);
        checkInt("mult_not_exc", int'(isExc), 0);
        doTxn(OP_DIV, -1, 1'b0, 1'b0, endCyc, isExc, nEnds);
        checkInt("div_done_cycle", endCyc, 34);
        doTxn(OP_DIV, 10, 1'b0, 1'b0, endCyc, isExc, nEnds);
        checkInt("div_fault_exc_cycle", endCyc, 11);
        checkInt("div_fault_is_exc", int'(isExc), 1);
        doTxn(OP_DIVM, -1, 1'b0, 1'b0, endCyc, isExc, nEnds);
        checkInt("divm_done_cycle", endCyc, 38);
        doTxn(OP_MULT, 10, 1'b0, 1'b0, endCyc, isExc, nEnds);
        checkInt("mult_ignores_zero_div", endCyc, 34);
        doTxn(OP_DIVM, 2, 1'b0, 1'b0, endCyc, isExc, nEnds);
        checkInt("divm_fault_in_fetch_ignored", endCyc, 38);
        doTxn(OP_DIVM, 37, 1'b0, 1'b0, endCyc, isExc, nEnds);
        checkInt("divm_fault_last_run_cycle", endCyc, 38);
        checkInt("divm_fault_last_run_exc", int'(isExc), 1);
        doTxn(OP_DIV, -1, 1'b1, 1'b0, endCyc, isExc, nEnds);
        checkInt("div_divisor_zero_end", endCyc, EARLY_EN ? 2 : 34);
        checkInt("div_divisor_zero_exc", int'(isExc), EARLY_EN ? 1 : 0);
        doTxn(OP_MULT, -1, 1'b0, 1'b1, endCyc, isExc, nEnds);
        checkInt("start_while_busy_single_end", nEnds, 1);

        // Reserved opcode must leave the sequencer idle.
        start = 1'b1;
        op = OP_RSVD;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkInt("reserved_op_not_busy", int'(busy), 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        // Abort a DIV in its tenth RUN cycle with reset.
        commitSelects();
        txnValid = 1'b1;
        txnStart = cyc;
        txnOp = OP_DIV;
        txnFault = -1;
        txnDz = 1'b0;
        start = 1'b1;
        op = OP_DIV;
        repeat (11) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        checkInt("pre_reset_busy", int'(busy), 1);
        reset = 1'b1;
        txnValid = 1'b0;
        lastMd = 1'b0;
        lastMem = 1'b0;
        #1;
        checkInt("async_reset_outputs_zero",
                 int'({busy, done, zero_div_exc, unit_reset, mult_div_sel, mem_a_sel, mem_b_sel,
                       mem_fetch, aux_a_load, aux_b_load, hi_load, lo_load}), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        doTxn(OP_MULT, -1, 1'b0, 1'b0, endCyc, isExc, nEnds);
        checkInt("mult_after_reset_done_cycle", endCyc, 34);

        for (int i = 0; i < 120; i++) begin
            o = 2'($urandom_range(0, 2));
            fault = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, fetchCycles(o) + ITER + 3);
            dz = ($urandom_range(0, 3) == 0);
            doTxn(o, fault, dz, ($urandom_range(0, 2) == 0), endCyc, isExc, nEnds);
            checkInt("random_single_end", nEnds, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
